// File: rtl/tx_ipv4.sv
// IPv4 transmit framer: checksums a 20-byte header, emits it, then passes L4 payload through.
// Define TX_IPV4_ID_INC_EN for an incrementing Identification field (otherwise it is fixed at 0).
module tx_ipv4 #(
    parameter int          OCT         = 8,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          MAX_PAYLOAD = 1480
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [31:0]    ip_addr,
    input  logic [31:0]    tx_dst_ip,
    input  logic [7:0]     tx_protocol,
    input  logic [15:0]    tx_len,
    input  logic           tx_start,
    output logic           tx_busy,
    output logic           tx_err,
    input  logic [OCT-1:0] tx_data_in,
    input  logic           tx_data_in_valid,
    output logic           tx_data_in_ready,
    input  logic           tx_ready,
    output logic           tx_payload_ipv4,
    output logic [OCT-1:0] tx_payload,
    output logic           tx_last,
    output logic           tx_done
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]    src_ip, dst_ip;
    logic [7:0]     proto;
    logic [15:0]    len, rem, csum, id;
    logic [19:0]    acc;
    logic [16:0]    fold_s;
    logic [4:0]     idx;
    logic [OCT-1:0] hdr_byte;
    logic           hdr_vld, hdr_last, err;
    logic           start_ok, data_fire, hdr_fire;
    logic [15:0]    sel_word;

    assign start_ok  = tx_start && (tx_len <= MAX_LEN);
    assign data_fire = tx_data_in_valid && tx_ready;
    assign hdr_fire  = hdr_vld && tx_ready;
    assign fold_s    = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    assign tx_busy   = (state == CSUM) || (state == FOLD) || (state == HDR) || (state == DATA);
    assign tx_err    = err;
    assign sel_word  = hdr_word(idx[4:1]);

`ifdef TX_IPV4_ID_INC_EN
    always_ff @(posedge RX_CLK) begin
        if (rst)
            id <= 16'h0000;
        else if (state == DONE)
            id <= id + 16'd1;
    end
`else
    assign id = 16'h0000;
`endif

    // Header word i; the checksum slot reads 0 while the sum is being accumulated.
    function automatic logic [15:0] hdr_word(input logic [3:0] i);
        case (i)
            4'd0:    hdr_word = 16'h4500;
            4'd1:    hdr_word = len + 16'd20;
            4'd2:    hdr_word = id;
            4'd3:    hdr_word = 16'h4000;
            4'd4:    hdr_word = {TTL, proto};
            4'd5:    hdr_word = csum;
            4'd6:    hdr_word = src_ip[31:16];
            4'd7:    hdr_word = src_ip[15:0];
            4'd8:    hdr_word = dst_ip[31:16];
            4'd9:    hdr_word = dst_ip[15:0];
            default: hdr_word = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge RX_CLK) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        tx_payload_ipv4  = hdr_vld;
        tx_payload       = hdr_byte;
        tx_last          = hdr_last;
        tx_data_in_ready = 1'b0;
        tx_done          = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = CSUM;
            CSUM: if (idx == 5'd9) state_nxt = FOLD;
            FOLD: state_nxt = HDR;
            HDR:  if (hdr_fire && idx == 5'd20) state_nxt = (len == 16'd0) ? DONE : DATA;
            DATA: begin
                tx_payload_ipv4  = tx_data_in_valid;
                tx_payload       = tx_data_in;
                tx_last          = tx_data_in_valid && (rem == 16'd1);
                tx_data_in_ready = data_fire;
                if (data_fire && rem == 16'd1) state_nxt = DONE;
            end
            DONE: begin
                tx_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are only meaningful while busy, so they carry no reset.
    always_ff @(posedge RX_CLK) begin
        if (state == IDLE && start_ok) begin
            src_ip <= ip_addr;
            dst_ip <= tx_dst_ip;
            proto  <= tx_protocol;
            len    <= tx_len;
            csum   <= 16'h0000;
        end else if (state == FOLD) begin
            csum   <= ~(fold_s[15:0] + {15'b0, fold_s[16]});
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            err      <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            rem      <= '0;
            hdr_byte <= '0;
            hdr_vld  <= 1'b0;
            hdr_last <= 1'b0;
        end else begin
            err <= (state == IDLE) && tx_start && (tx_len > MAX_LEN);
            case (state)
                IDLE: begin
                    acc      <= '0;
                    idx      <= '0;
                    hdr_vld  <= 1'b0;
                    hdr_last <= 1'b0;
                    if (start_ok) rem <= tx_len;
                end
                CSUM: begin
                    acc <= acc + {4'b0, hdr_word(idx[3:0])};
                    idx <= (idx == 5'd9) ? 5'd0 : idx + 5'd1;
                end
                HDR: if (!hdr_vld || tx_ready) begin
                    if (idx < 5'd20) begin
                        hdr_byte <= idx[0] ? sel_word[7:0] : sel_word[15:8];
                        hdr_vld  <= 1'b1;
                        hdr_last <= (idx == 5'd19) && (len == 16'd0);
                        idx      <= idx + 5'd1;
                    end else begin
                        hdr_vld  <= 1'b0;
                        hdr_last <= 1'b0;
                    end
                end
                DATA: if (data_fire) rem <= rem - 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_ipv4.sv
// Directed bench for tx_ipv4: header bytes, payload pass-through, stalls, limits and reset abort.
module tb_tx_ipv4;
    logic        RX_CLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ip_addr = 32'hC0A80001;
    logic [31:0] tx_dst_ip = 32'hC0A800C7;
    logic [7:0]  tx_protocol = 8'h11;
    logic [15:0] tx_len = 16'd0;
    logic        tx_start = 1'b0;
    logic        tx_busy, tx_err, tx_data_in_ready, tx_payload_ipv4, tx_last, tx_done;
    logic [7:0]  tx_data_in, tx_payload;
    logic        tx_data_in_valid;
    logic        tx_ready = 1'b1;

    logic        src_en = 1'b1, src_clr = 1'b0, tgl = 1'b0;
    logic [15:0] src_idx = 16'd0;
    int          cyc = 0;

    int          n_chk = 0, n_pass = 0;
    logic [7:0]  cap_q[$];
    int          cap_cyc[$];
    bit          cap_last[$];
    int          done_n = 0, err_n = 0, rdy_n = 0, stall_bad = 0;
    bit          held_pend = 0;
    logic [7:0]  held_byte;
    logic [7:0]  exp_h [20];
    logic [15:0] exp_id = 16'h0000;
    int          start_cyc = 0;

    tx_ipv4 dut (
        .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr), .tx_dst_ip(tx_dst_ip),
        .tx_protocol(tx_protocol), .tx_len(tx_len), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_err(tx_err), .tx_data_in(tx_data_in), .tx_data_in_valid(tx_data_in_valid),
        .tx_data_in_ready(tx_data_in_ready), .tx_ready(tx_ready),
        .tx_payload_ipv4(tx_payload_ipv4), .tx_payload(tx_payload), .tx_last(tx_last),
        .tx_done(tx_done)
    );

    initial forever #5 RX_CLK = ~RX_CLK;

    assign tx_data_in       = src_idx[7:0] ^ 8'h5A;
    assign tx_data_in_valid = src_en;

    always @(posedge RX_CLK) begin
        cyc <= cyc + 1;
        if (src_clr) src_idx <= 16'd0;
        else if (tx_data_in_ready) src_idx <= src_idx + 16'd1;
    end

    initial forever begin
        @(posedge RX_CLK);
        #1 tx_ready = tgl ? ~tx_ready : 1'b1;
    end

    // Outputs are sampled mid-cycle; a byte counts as transferred when valid & ready.
    always @(negedge RX_CLK) begin
        if (rst) begin
            held_pend = 0;
        end else begin
            if (held_pend && (!tx_payload_ipv4 || tx_payload !== held_byte)) stall_bad++;
            held_pend = 0;
            if (tx_payload_ipv4 && tx_ready) begin
                cap_q.push_back(tx_payload);
                cap_cyc.push_back(cyc);
                cap_last.push_back(tx_last);
            end else if (tx_payload_ipv4) begin
                held_pend = 1;
                held_byte = tx_payload;
            end
            if (tx_done) done_n++;
            if (tx_err) err_n++;
            if (tx_data_in_ready) rdy_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic build_hdr(input logic [15:0] len, input logic [7:0] proto,
                             input logic [31:0] src, input logic [31:0] dst, input logic [15:0] id);
        logic [31:0] s;
        logic [15:0] tl;
        tl = len + 16'd20;
        exp_h = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00, 8'd64, proto,
                  8'h00, 8'h00, src[31:24], src[23:16], src[15:8], src[7:0],
                  dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        s = 0;
        for (int i = 0; i < 20; i += 2) s += {16'h0, exp_h[i], exp_h[i+1]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        exp_h[10] = ~s[15:8];
        exp_h[11] = ~s[7:0];
    endtask

    task automatic send(input logic [15:0] len, input int poke, output int base, output int d0);
        @(posedge RX_CLK); #1 src_clr = 1'b1;
        @(posedge RX_CLK); #1 src_clr = 1'b0;
        base = cap_q.size();
        d0 = done_n;
        tx_len = len;
        tx_start = 1'b1;
        @(posedge RX_CLK); #1;
        start_cyc = cyc;
        tx_start = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(posedge RX_CLK);
            #1 tx_len = 16'd50; tx_start = 1'b1;
            @(posedge RX_CLK); #1 tx_start = 1'b0; tx_len = len;
        end
        for (int k = 0; k < 4000 && done_n == d0; k++) @(posedge RX_CLK);
        #1;
    endtask

    task automatic check_dgram(input string tag, input int base, input int d0, input logic [15:0] len);
        int bad, nlast, lidx, n;
        build_hdr(len, tx_protocol, ip_addr, tx_dst_ip, exp_id);
        n = cap_q.size() - base;
        check({tag, "_done"}, done_n - d0, 1);
        check({tag, "_nbytes"}, n, len + 20);
        for (int i = 0; i < 20; i++)
            check($sformatf("%s_h%0d", tag, i), (i < n) ? {24'h0, cap_q[base+i]} : 32'hDEAD, exp_h[i]);
        bad = 0;
        for (int i = 0; i < len; i++) begin
            logic [7:0] e;
            e = 8'(i) ^ 8'h5A;
            if (20 + i >= n || cap_q[base+20+i] !== e) bad++;
        end
        check({tag, "_payload_bad"}, bad, 0);
        nlast = 0; lidx = -1;
        for (int i = 0; i < n; i++) if (cap_last[base+i]) begin nlast++; lidx = i; end
        check({tag, "_nlast"}, nlast, 1);
        check({tag, "_last_pos"}, lidx, len + 19);
`ifdef TX_IPV4_ID_INC_EN
        exp_id = exp_id + 16'd1;
`endif
    endtask

    initial begin
        int base, d0, e0, r0, s0;
        repeat (3) @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("rst_busy", tx_busy, 0);
        check("rst_outs", {tx_err, tx_data_in_ready, tx_payload_ipv4, tx_last, tx_done}, 0);
        check("rst_payload", tx_payload, 8'h00);
        @(posedge RX_CLK); #1 rst = 1'b0;

        // 1: basic datagram with hand-computed checksum
        send(16'd95, 0, base, d0);
        check("t1_lat", cap_cyc.size() > base ? cap_cyc[base] - start_cyc : -1, 12);
        check("t1_totlen", cap_q.size() > base + 3 ? {cap_q[base+2], cap_q[base+3]} : 0, 16'h0073);
        check("t1_csum", cap_q.size() > base + 11 ? {cap_q[base+10], cap_q[base+11]} : 0, 16'hB861);
        check_dgram("t1", base, d0, 16'd95);

        // 2: downstream stalls every other cycle
        tgl = 1'b1;
        s0 = stall_bad;
        send(16'd95, 0, base, d0);
        tgl = 1'b0;
        check_dgram("t2", base, d0, 16'd95);
        check("t2_held_stable", stall_bad - s0, 0);

        // 3: empty payload
        r0 = rdy_n;
        send(16'd0, 0, base, d0);
        check("t3_lat", cap_cyc.size() > base ? cap_cyc[base] - start_cyc : -1, 12);
        check_dgram("t3", base, d0, 16'd0);
        check("t3_no_ready", rdy_n - r0, 0);

        // 4: oversize request, start while busy, largest legal payload
        e0 = err_n; base = cap_q.size();
        @(posedge RX_CLK); #1 tx_len = 16'd1481; tx_start = 1'b1;
        @(posedge RX_CLK); #1 tx_start = 1'b0;
        @(negedge RX_CLK);
        check("t4_busy", tx_busy, 0);
        repeat (20) @(posedge RX_CLK);
        #1;
        check("t4_err_pulse", err_n - e0, 1);
        check("t4_no_out", cap_q.size() - base, 0);
        send(16'd3, 4, base, d0);
        repeat (30) @(posedge RX_CLK);
        #1;
        check_dgram("t4b", base, d0, 16'd3);
        check("t4b_one_done", done_n - d0, 1);
        e0 = err_n;
        send(16'd1480, 0, base, d0);
        check_dgram("t4c", base, d0, 16'd1480);
        check("t4c_no_err", err_n - e0, 0);

        // 6: reset in the middle of the payload
        d0 = done_n; r0 = rdy_n; e0 = cap_last.size();
        @(posedge RX_CLK); #1 src_clr = 1'b1;
        @(posedge RX_CLK); #1 src_clr = 1'b0; tx_len = 16'd40; tx_start = 1'b1;
        @(posedge RX_CLK); #1 tx_start = 1'b0;
        for (int k = 0; k < 200 && rdy_n - r0 < 10; k++) @(posedge RX_CLK);
        #1 rst = 1'b1;
        @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("t6_reached_data", rdy_n - r0 >= 10, 1);
        check("t6_busy", tx_busy, 0);
        check("t6_outs", {tx_err, tx_data_in_ready, tx_payload_ipv4, tx_last, tx_done}, 0);
        check("t6_payload", tx_payload, 8'h00);
        @(posedge RX_CLK); #1 rst = 1'b0;
        exp_id = 16'h0000;
        repeat (5) @(posedge RX_CLK);
        check("t6_no_done", done_n - d0, 0);
        s0 = 0;
        for (int i = e0; i < cap_last.size(); i++) s0 += cap_last[i];
        check("t6_no_last", s0, 0);

        // 5: back-to-back after reset; ID and checksum track each other
        send(16'd95, 0, base, d0);
        check("t5a_csum", cap_q.size() > base + 11 ? {cap_q[base+10], cap_q[base+11]} : 0, 16'hB861);
        check_dgram("t5a", base, d0, 16'd95);
        send(16'd95, 0, base, d0);
`ifdef TX_IPV4_ID_INC_EN
        check("t5b_csum", cap_q.size() > base + 11 ? {cap_q[base+10], cap_q[base+11]} : 0, 16'hB860);
`else
        check("t5b_csum", cap_q.size() > base + 11 ? {cap_q[base+10], cap_q[base+11]} : 0, 16'hB861);
`endif
        check_dgram("t5b", base, d0, 16'd95);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
